mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative 32-bit signed multiplier/divider (MDU) directly downstream of the multicycle control unit.
- Consumes the control unit's MULT_OP/DIV_OP requests plus register A/B operands; produces HI/LO results for the HI/LO registers (MFHI/MFLO path).
- Radix-2 shift-add multiply and restoring divide, one iteration per clock, with a busy/done handshake so control can stall on busy instead of counting cycles itself.

Parameters:
- WIDTH, 32, operand width; hi/lo are WIDTH bits each, product is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; low immediately clears all state, including mid-operation.
- start_mult  in  1  one-cycle request: signed multiply a*b.
- start_div  in  1  one-cycle request: signed divide a/b.
- a  in  WIDTH  operand A (multiplicand / dividend), sampled at start.
- b  in  WIDTH  operand B (multiplier / divisor), sampled at start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when hi/lo are updated.
- div_zero  out  1  high with done when the divide had b==0; held until next start.
- hi  out  WIDTH  mult: product[63:32]; div: remainder.
- lo  out  WIDTH  mult: product[31:0]; div: quotient.

Behaviour:
- Reset (reset low): state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0, internal regs=0. An in-flight operation is aborted with no result.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - Exactly one start high at an edge: latch |a|, |b|, result sign(s), op type; counter=WIDTH; go to RUN; busy=1 from that edge.
  - start_mult and start_div both high: illegal; ignored, stay IDLE.
  - Start while busy: ignored; no queueing.
- Divide by zero: start_div with b==0 skips RUN and goes to DONE. hi/lo keep previous values; div_zero=1.
- RUN: one iteration per clock, counter decrements; after WIDTH iterations (counter reaches 0) go to FIX.
  - Multiply: shift-add on unsigned magnitudes into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract on magnitudes.
- FIX: apply sign correction and write hi/lo; go to DONE.
  - Product is negated if sign(a)!=sign(b).
  - Quotient is negated if sign(a)!=sign(b); truncation is toward zero.
  - Remainder takes the sign of the dividend.
- DONE: done=1 for exactly this cycle, busy=0; return to IDLE. A start sampled in DONE is ignored.
- Latency: start sampled at edge k → hi/lo valid and done high after edge k+WIDTH+2 (34 for WIDTH=32); busy high after edges k..k+WIDTH+1. Div-by-zero: done after edge k+1.
- Magnitudes are unsigned WIDTH-bit, so |0x80000000|=0x80000000 is exact.
- 0x80000000 / -1 yields lo=0x80000000, hi=0 (wraps; no overflow flag).
- hi/lo change only in FIX; they hold between operations.

Optional Feature:
- Macro: MDU_UNSIGNED_EN.
- Defined: extra input port is_unsigned (1 bit), sampled with start. When it is 1, operands are treated as unsigned (MULTU/DIVU) and sign correction in FIX is skipped.
- Not defined: the port is absent and all operations are signed.
- Latency is identical in both builds.

Test Plan:
- Signed multiply: start_mult, a=7, b=0xFFFFFFFD (-3) → after 34 clocks done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy low same cycle as done.
- Extreme multiply: a=b=0x80000000 → hi=0x40000000, lo=0x00000000.
- Signed divide: start_div, a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); then a=100, b=7 → lo=14, hi=2.
- Divide by zero: preload hi=2, lo=14; start_div, a=5, b=0 → done and div_zero high after 1 clock; hi=2, lo=14 unchanged. A following valid op clears div_zero.
- Handshake:
  - start_mult and start_div together → busy stays 0, no done.
  - start_mult pulsed again at cycle 10 of a running op → ignored; only one done, with the first operation's result.
- Reset mid-operation: drop reset at cycle 15 of a multiply → busy, done, hi, lo immediately 0. Release reset and issue a new start_div, a=9, b=3 → lo=3, hi=0 after 34 clocks.

Source files
------------

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//
// Iterative signed multiplier / divider feeding the HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one iteration per clock.
// Control stalls on busy_o and picks the result up on the done_o pulse.
//
// Operands are reduced to unsigned magnitudes when the operation is
// accepted. The sign of the result is restored in a single FIX cycle at the
// end of the operation.
//
// Timing: a start sampled at edge k gives done_o and valid hi_o/lo_o after
// edge k+WIDTH+2. A divide by zero gives done_o after edge k+1. In that case
// hi_o/lo_o are left unchanged and div_zero_o is raised.
//
// Build option:
//   MDU_UNSIGNED_EN - adds is_unsigned_i. When it is high at start, the
//                     operands are treated as unsigned (MULTU/DIVU) and the
//                     sign fix-up is skipped. The latency is the same.
//
// Ports:
//   clock_i        clock, rising edge
//   reset_ni       asynchronous reset, active low; aborts any operation
//   start_mult_i   one-cycle request: signed multiply a*b
//   start_div_i    one-cycle request: signed divide a/b
//   is_unsigned_i  (MDU_UNSIGNED_EN only) treat operands as unsigned
//   a_i, b_i       operands, sampled with the start request
//   busy_o         operation in progress
//   done_o         one-cycle pulse when the result is final
//   div_zero_o     last divide had b==0; held until the next accepted start
//   hi_o           product[2W-1:W] / remainder
//   lo_o           product[W-1:0]  / quotient
// ---------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             start_mult_i,
  input  logic             start_div_i,
`ifdef MDU_UNSIGNED_EN
  input  logic             is_unsigned_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_div_q, op_div_d;
  logic               neg_q, neg_d;     // negate product / quotient
  logic               rneg_q, rneg_d;   // negate remainder (dividend sign)
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand (mult) or divisor (div)
  logic [2*WIDTH-1:0] acc_q, acc_d;     // {partial/remainder, multiplier/quotient}
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // -------------------------------------------------------------------------
  // Operand conditioning
  // -------------------------------------------------------------------------
  logic             uns;
  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             start_one;

`ifdef MDU_UNSIGNED_EN
  assign uns = is_unsigned_i;
`else
  assign uns = 1'b0;
`endif

  assign sa        = a_i[WIDTH-1] & ~uns;
  assign sb        = b_i[WIDTH-1] & ~uns;
  // The magnitude of the most negative value is still exact as an unsigned number.
  assign mag_a     = sa ? -a_i : a_i;
  assign mag_b     = sb ? -b_i : b_i;
  assign start_one = start_mult_i ^ start_div_i;

  // -------------------------------------------------------------------------
  // Datapath for one iteration
  // -------------------------------------------------------------------------
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               div_by_zero;

  // Multiply: conditionally add the multiplicand to the upper half, then
  // shift the whole accumulator right. The carry enters at the top.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};

  // Divide: shift {rem, quo} left. The shifted remainder needs WIDTH+1 bits
  // because the divisor may be as large as 2^(WIDTH-1).
  assign div_sh    = {acc_q, 1'b0};
  assign div_ge    = div_sh[2*WIDTH:WIDTH] >= {1'b0, opnd_q};
  // When div_ge is set the difference is below the divisor, so WIDTH bits are enough.
  assign div_trial = div_sh[2*WIDTH-1:WIDTH] - opnd_q;

  assign prod_fix    = neg_q  ? -acc_q : acc_q;
  assign quo_fix     = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix     = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign div_by_zero = op_div_q && (opnd_q == '0);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_div_d = op_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      S_IDLE: begin
        // Two simultaneous start requests are illegal and are dropped.
        if (start_one) begin
          op_div_d = start_div_i;
          neg_d    = sa ^ sb;
          rneg_d   = sa;
          dz_d     = 1'b0;
          opnd_d   = start_div_i ? mag_b : mag_a;
          acc_d    = {{WIDTH{1'b0}}, (start_div_i ? mag_a : mag_b)};
          cnt_d    = CNT_INIT;
          // For a divide by zero, skip the iterations. FIX then sees a zero
          // divisor and leaves hi/lo as they are.
          state_d  = (start_div_i && (b_i == '0)) ? S_FIX : S_RUN;
        end
      end

      S_RUN: begin
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (!op_div_q) begin
            if (acc_q[0]) acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
          end else begin
            if (div_ge) acc_d = {div_trial, acc_q[WIDTH-2:0], 1'b1};
            else        acc_d = div_sh[2*WIDTH-1:0];
          end
        end
      end

      S_FIX: begin
        state_d = S_DONE;
        if (div_by_zero) begin
          dz_d = 1'b1;
        end else if (!op_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end

      // A start request that arrives in this cycle is not accepted.
      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_div_q <= op_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy_o     = (state_q == S_RUN) || (state_q == S_FIX);
  assign done_o     = (state_q == S_DONE);
  assign div_zero_o = dz_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         rst_n = 1'b1;
  logic         sm = 1'b0, sd = 1'b0, uns = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clock_i      (clock),
    .reset_ni     (rst_n),
    .start_mult_i (sm),
    .start_div_i  (sd),
`ifdef MDU_UNSIGNED_EN
    .is_unsigned_i(uns),
`endif
    .a_i          (a),
    .b_i          (b),
    .busy_o       (busy),
    .done_o       (done),
    .div_zero_o   (dz),
    .hi_o         (hi),
    .lo_o         (lo)
  );

  // Reference arithmetic: returns {hi, lo}.
  function automatic logic [2*W-1:0] model_res(input bit is_div, input logic [W-1:0] x,
                                               input logic [W-1:0] y, input bit u);
    longint sx, sy, q, r;
    sx = u ? longint'({32'd0, x}) : longint'($signed(x));
    sy = u ? longint'({32'd0, y}) : longint'($signed(y));
    if (!is_div) return sx * sy;
    if (sy == 0) return '0;
    q = sx / sy;
    r = sx % sy;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  // Transaction-level model: an operation counts down to completion.
  // During that time no start request is taken, and none is taken in the done cycle.
  logic         m_busy = 0, m_done = 0, m_dz = 0, p_dz = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int           m_left = 0;

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_done <= 0; m_dz <= 0; m_hi <= '0; m_lo <= '0; m_left <= 0;
    end else begin
      m_done <= 0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 0; m_done <= 1; m_dz <= p_dz;
          if (!p_dz) begin m_hi <= p_hi; m_lo <= p_lo; end
        end
      end else if (!m_done && (sm ^ sd)) begin
        {p_hi, p_lo} <= model_res(sd, a, b, uns);
        p_dz   <= sd && (b == '0);
        m_busy <= 1;
        m_dz   <= 0;
        m_left <= (sd && (b == '0)) ? 1 : W + 2;
      end
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("busy", W'(busy), W'(m_busy));
    chk("done", W'(done), W'(m_done));
    chk("div_zero", W'(dz), W'(m_dz));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  end

  task automatic issue(input bit m, input bit d, input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge clock); #1;
    sm = m; sd = d; a = x; b = y;
    @(posedge clock); #1;
    sm = 0; sd = 0;
  endtask

  // Returns the number of falling edges counted up to the done pulse (0 on timeout).
  task automatic wait_done(input string nm, output int n);
    n = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clock);
      if (done) begin n = i; break; end
    end
    checks++;
    if (n == 0) begin
      failures++;
      $display("FAIL %s: no done within 50 cycles", nm);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return W'($urandom_range(0, 20));
      default: return W'($urandom());
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, cnt;
    #2 rst_n = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", W'(busy), '0);
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);
    @(negedge clock) rst_n = 1;

    // Signed multiply 7 * -3
    issue(1, 0, 32'd7, 32'hFFFF_FFFD);
    wait_done("mul1", n);
    chk("mul1_lat", W'(n), W'(35));
    chk("mul1_busy", W'(busy), '0);
    chk("mul1_hi", hi, 32'hFFFF_FFFF);
    chk("mul1_lo", lo, 32'hFFFF_FFEB);

    // Most negative value squared
    issue(1, 0, 32'h8000_0000, 32'h8000_0000);
    wait_done("mul2", n);
    chk("mul2_hi", hi, 32'h4000_0000);
    chk("mul2_lo", lo, 32'h0);

    // Signed divides
    issue(0, 1, 32'hFFFF_FFF9, 32'd2);
    wait_done("div1", n);
    chk("div1_lo", lo, 32'hFFFF_FFFD);
    chk("div1_hi", hi, 32'hFFFF_FFFF);
    issue(0, 1, 32'd100, 32'd7);
    wait_done("div2", n);
    chk("div2_lo", lo, 32'd14);
    chk("div2_hi", hi, 32'd2);

    // Divide by zero keeps hi/lo
    issue(0, 1, 32'd5, 32'd0);
    wait_done("dz", n);
    chk("dz_lat", W'(n), W'(2));
    chk("dz_flag", W'(dz), W'(1));
    chk("dz_hi", hi, 32'd2);
    chk("dz_lo", lo, 32'd14);
    issue(1, 0, 32'd3, 32'd4);
    chk("dz_clear", W'(dz), '0);
    wait_done("mul3", n);
    chk("mul3_lo", lo, 32'd12);

    // Two start requests together are dropped
    issue(1, 1, 32'd9, 32'd9);
    cnt = 0;
    repeat (5) begin @(negedge clock); cnt += int'(busy) + int'(done); end
    chk("both_ignored", W'(cnt), '0);

    // A start request while busy is ignored
    issue(1, 0, 32'd5, 32'd6);
    repeat (9) @(posedge clock);
    issue(1, 0, 32'd100, 32'd100);
    wait_done("busy_start", n);
    chk("busy_start_lo", lo, 32'd30);
    cnt = 0;
    repeat (40) begin @(negedge clock); cnt += int'(done); end
    chk("busy_start_one_done", W'(cnt), '0);

    // Overflow case wraps
    issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("ovf", n);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);

`ifdef MDU_UNSIGNED_EN
    uns = 1;
    issue(1, 0, 32'hFFFF_FFFF, 32'd2);
    wait_done("mulu", n);
    chk("mulu_hi", hi, 32'd1);
    chk("mulu_lo", lo, 32'hFFFF_FFFE);
    uns = 0;
`endif

    // Reset in the middle of an operation
    issue(1, 0, 32'd123, 32'd456);
    repeat (14) @(posedge clock);
    #3 rst_n = 0;
    #1;
    chk("mid_rst_busy", W'(busy), '0);
    chk("mid_rst_done", W'(done), '0);
    chk("mid_rst_hi", hi, '0);
    chk("mid_rst_lo", lo, '0);
    @(negedge clock) rst_n = 1;
    issue(0, 1, 32'd9, 32'd3);
    wait_done("post_rst", n);
    chk("post_rst_lo", lo, 32'd3);
    chk("post_rst_hi", hi, 32'd0);

    // Random traffic, including start requests that arrive while busy or in the done cycle
    for (int i = 0; i < 1500; i++) begin
      @(posedge clock); #1;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 9))
          0:       begin sm = 1; sd = 1; end
          1, 2, 3, 4: begin sm = 1; sd = 0; end
          default: begin sm = 0; sd = 1; end
        endcase
        a = pick(); b = pick();
`ifdef MDU_UNSIGNED_EN
        uns = 1'($urandom_range(0, 1));
`endif
      end else begin
        sm = 0; sd = 0;
      end
    end
    @(posedge clock); #1;
    sm = 0; sd = 0;
    repeat (50) @(posedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
